// File: rtl/mem_bank_cfg_pkg.sv
// Shared types and helpers for the memory-bank configuration loader.
package mem_bank_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SETUP,
    PULSE,
    HOLD,
    DONE
  } cfg_state_t;

  // The timer is loaded with (cycles - 1), so the widest phase needs clog2(max) bits.
  function automatic int timer_width(input int setup_c, input int pulse_c, input int hold_c);
    int m;
    m = setup_c;
    if (pulse_c > m) m = pulse_c;
    if (hold_c > m) m = hold_c;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/mem_bank_pulse_timer.sv
// Loadable down-counter with a zero flag; times the SETUP/PULSE/HOLD phases.
module mem_bank_pulse_timer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - ONE;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/mem_bank_cfg_loader.sv
// Serial bitstream to bank write-cycle sequencer: one bit per address with
// programmable setup/pulse/hold timing around each enable strobe.
module mem_bank_cfg_loader
  import mem_bank_cfg_pkg::*;
#(
  parameter int ADDR_WIDTH   = 7,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 1,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_bits,
  input  logic                  abort,
  input  logic                  bs_valid,
  input  logic                  bs_data,
  output logic                  bs_ready,
  output logic                  enable,
  output logic [0:ADDR_WIDTH-1] address,
  output logic                  data_in,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int TW = timer_width(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES);
  localparam logic [TW-1:0] SETUP_LOAD = TW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLD_CYCLES - 1);
  localparam logic [ADDR_WIDTH+1:0] ADDR_SPAN = {2'b01, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   REMAIN_ONE = (ADDR_WIDTH + 1)'(1);

  cfg_state_t            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [ADDR_WIDTH:0]   remain_reg, remain_next;
  logic                  data_reg, data_next;
  logic                  enable_reg, enable_next;
  logic                  error_reg, error_next;
  logic                  tmr_load, tmr_zero;
  logic [TW-1:0]         tmr_val;
  logic [ADDR_WIDTH+1:0] range_end;

  // One past the last address the request would touch.
  assign range_end = {2'b00, base_addr} + {1'b0, num_bits};

  mem_bank_pulse_timer #(.WIDTH(TW)) u_timer (
    .clk      (prog_clk),
    .srst     (pReset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      remain_reg <= '0;
      data_reg   <= 1'b0;
      enable_reg <= 1'b0;
      error_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      remain_reg <= remain_next;
      data_reg   <= data_next;
      enable_reg <= enable_next;
      error_reg  <= error_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    remain_next = remain_reg;
    data_next   = data_reg;
    enable_next = 1'b0;
    error_next  = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          if (num_bits == '0) begin
            state_next = DONE;
          end else if (range_end <= ADDR_SPAN) begin
            state_next  = FETCH;
            addr_next   = base_addr;
            remain_next = num_bits;
          end else begin
            error_next = 1'b1;
          end
        end
      end
      FETCH: begin
        if (abort) begin
          state_next = IDLE;
        end else if (bs_valid) begin
          data_next  = bs_data;
          state_next = SETUP;
          tmr_load   = 1'b1;
          tmr_val    = SETUP_LOAD;
        end
      end
      SETUP: begin
        if (abort) begin
          state_next = IDLE;
        end else if (tmr_zero) begin
          state_next  = PULSE;
          enable_next = 1'b1;
          tmr_load    = 1'b1;
          tmr_val     = PULSE_LOAD;
        end
      end
      PULSE: begin
        // enable is registered, so it must be re-requested every cycle we stay here.
        if (abort) begin
          state_next = IDLE;
        end else if (tmr_zero) begin
          state_next = HOLD;
          tmr_load   = 1'b1;
          tmr_val    = HOLD_LOAD;
        end else begin
          enable_next = 1'b1;
        end
      end
      HOLD: begin
        if (abort) begin
          state_next = IDLE;
        end else if (tmr_zero) begin
          remain_next = remain_reg - REMAIN_ONE;
          if (remain_reg == REMAIN_ONE) begin
            state_next = DONE;
          end else begin
            addr_next  = addr_reg + ADDR_ONE;
            state_next = FETCH;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bs_ready = (state_reg == FETCH);
  assign busy     = (state_reg == FETCH) || (state_reg == SETUP) ||
                    (state_reg == PULSE) || (state_reg == HOLD);
  assign done     = (state_reg == DONE);
  assign enable   = enable_reg;
  assign address  = addr_reg;
  assign data_in  = data_reg;
  assign error    = error_reg;

endmodule

// File: tb/tb_mem_bank_cfg_loader.sv
// Directed bench: two loaders (default timing and 2/3/2 timing) checked every
// cycle against a transaction-level model, plus hand-computed literal checks.
module tb_mem_bank_cfg_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s   [2];
  logic       start_s [2];
  logic       abort_s [2];
  logic       valid_s [2];
  logic       bdata_s [2];
  logic [6:0] base_s  [2];
  logic [7:0] nb_s    [2];
  logic       ready_s [2];
  logic       enable_s[2];
  logic       data_s  [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic       error_s [2];
  logic [0:6] addr_s  [2];

  int vectors = 0;
  int miscompares = 0;

  mem_bank_cfg_loader dut0 (
    .prog_clk(clk), .pReset(rst_s[0]), .start(start_s[0]), .base_addr(base_s[0]),
    .num_bits(nb_s[0]), .abort(abort_s[0]), .bs_valid(valid_s[0]), .bs_data(bdata_s[0]),
    .bs_ready(ready_s[0]), .enable(enable_s[0]), .address(addr_s[0]), .data_in(data_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .error(error_s[0])
  );

  mem_bank_cfg_loader #(.ADDR_WIDTH(7), .SETUP_CYCLES(2), .PULSE_CYCLES(3), .HOLD_CYCLES(2)) dut1 (
    .prog_clk(clk), .pReset(rst_s[1]), .start(start_s[1]), .base_addr(base_s[1]),
    .num_bits(nb_s[1]), .abort(abort_s[1]), .bs_valid(valid_s[1]), .bs_data(bdata_s[1]),
    .bs_ready(ready_s[1]), .enable(enable_s[1]), .address(addr_s[1]), .data_in(data_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .error(error_s[1])
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: a write occupies t = 1..S+P+H cycles after the bit is taken;
  // enable is expected for t in (S, S+P].
  int S_c[2] = '{1, 2};
  int P_c[2] = '{1, 3};
  int H_c[2] = '{1, 2};
  int m_active[2] = '{0, 0};
  int m_wait[2]   = '{0, 0};
  int m_t[2]      = '{0, 0};
  int m_addr[2]   = '{0, 0};
  int m_data[2]   = '{0, 0};
  int m_left[2]   = '{0, 0};
  int m_done[2]   = '{0, 0};
  int m_err[2]    = '{0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_s[i]) begin
        m_active[i] = 0; m_wait[i] = 0; m_t[i] = 0; m_addr[i] = 0;
        m_data[i] = 0; m_left[i] = 0; m_done[i] = 0; m_err[i] = 0;
      end else begin
        int was_done;
        was_done = m_done[i];
        m_done[i] = 0;
        m_err[i] = 0;
        if (m_active[i] == 0) begin
          if (was_done == 0 && start_s[i] && !abort_s[i]) begin
            if (nb_s[i] == 0) m_done[i] = 1;
            else if (int'(base_s[i]) + int'(nb_s[i]) > 128) m_err[i] = 1;
            else begin
              m_active[i] = 1; m_wait[i] = 1; m_t[i] = 0;
              m_addr[i] = int'(base_s[i]); m_left[i] = int'(nb_s[i]);
            end
          end
        end else if (abort_s[i]) begin
          m_active[i] = 0; m_wait[i] = 0; m_t[i] = 0;
        end else if (m_wait[i] != 0) begin
          if (valid_s[i]) begin
            m_data[i] = int'(bdata_s[i]); m_wait[i] = 0; m_t[i] = 1;
          end
        end else begin
          m_t[i]++;
          if (m_t[i] > S_c[i] + P_c[i] + H_c[i]) begin
            m_t[i] = 0;
            m_left[i]--;
            if (m_left[i] == 0) begin
              m_active[i] = 0; m_done[i] = 1;
            end else begin
              m_addr[i]++; m_wait[i] = 1;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int exp_en;
      exp_en = (m_active[i] != 0 && m_wait[i] == 0 &&
                m_t[i] > S_c[i] && m_t[i] <= S_c[i] + P_c[i]) ? 1 : 0;
      check($sformatf("u%0d_busy", i),    int'(busy_s[i]),   m_active[i]);
      check($sformatf("u%0d_ready", i),   int'(ready_s[i]),  (m_active[i] != 0 && m_wait[i] != 0) ? 1 : 0);
      check($sformatf("u%0d_enable", i),  int'(enable_s[i]), exp_en);
      check($sformatf("u%0d_address", i), int'(addr_s[i]),   m_addr[i]);
      check($sformatf("u%0d_data_in", i), int'(data_s[i]),   m_data[i]);
      check($sformatf("u%0d_done", i),    int'(done_s[i]),   m_done[i]);
      check($sformatf("u%0d_error", i),   int'(error_s[i]),  m_err[i]);
    end
  end

  // Transaction log used by the literal checks.
  int ncyc = 0;
  int start_cyc[2], done_cyc[2], done_cnt[2], err_cnt[2], en_cyc[2], wr_cnt[2];
  int wr_log[2][8];
  logic prev_en[2] = '{1'b0, 1'b0};

  always @(posedge clk) ncyc++;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (start_s[i]) start_cyc[i] = ncyc;
      if (done_s[i]) begin done_cyc[i] = ncyc; done_cnt[i]++; end
      if (error_s[i]) err_cnt[i]++;
      if (enable_s[i]) en_cyc[i]++;
      if (enable_s[i] && !prev_en[i] && wr_cnt[i] < 8) begin
        wr_log[i][wr_cnt[i]] = int'(addr_s[i]) * 2 + int'(data_s[i]);
        wr_cnt[i]++;
      end
      prev_en[i] = enable_s[i];
    end
  end

  task automatic clear_log();
    for (int i = 0; i < 2; i++) begin
      start_cyc[i] = 0; done_cyc[i] = -100; done_cnt[i] = 0;
      err_cnt[i] = 0; en_cyc[i] = 0; wr_cnt[i] = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int i, input int base, input int nb);
    start_s[i] = 1'b1;
    base_s[i] = 7'(base);
    nb_s[i] = 8'(nb);
    step();
    start_s[i] = 1'b0;
  endtask

  task automatic wait_ready(input int i);
    int k;
    k = 0;
    while (!ready_s[i] && k < 100) begin
      step();
      k++;
    end
    check($sformatf("u%0d_ready_wait", i), int'(ready_s[i]), 1);
  endtask

  task automatic wait_enable(input int i);
    int k;
    k = 0;
    while (!enable_s[i] && k < 100) begin
      step();
      k++;
    end
    check($sformatf("u%0d_enable_wait", i), int'(enable_s[i]), 1);
  endtask

  // Offer one bit; with gap>0, first hold bs_valid low for gap FETCH cycles.
  task automatic send_bit(input int i, input logic b, input int gap);
    if (gap > 0) begin
      valid_s[i] = 1'b0;
      bdata_s[i] = ~b;
      wait_ready(i);
      repeat (gap) step();
    end
    valid_s[i] = 1'b1;
    bdata_s[i] = b;
    wait_ready(i);
    step();
    valid_s[i] = 1'b0;
    bdata_s[i] = ~b;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_s[i] = 1'b1; start_s[i] = 1'b0; abort_s[i] = 1'b0; valid_s[i] = 1'b0;
      bdata_s[i] = 1'b0; base_s[i] = '0; nb_s[i] = '0;
    end
    clear_log();
    repeat (3) step();
    check("reset_address", int'(addr_s[0]), 0);
    check("reset_busy", int'(busy_s[1]), 0);
    check("reset_ready", int'(ready_s[0]), 0);
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;
    step();

    // Normal run at default timing.
    clear_log();
    do_start(0, 5, 3);
    send_bit(0, 1'b1, 0);
    send_bit(0, 1'b0, 0);
    send_bit(0, 1'b1, 0);
    repeat (8) step();
    check("s1_latency", done_cyc[0] - start_cyc[0], 13);
    check("s1_done_cnt", done_cnt[0], 1);
    check("s1_writes", wr_cnt[0], 3);
    check("s1_w0", wr_log[0][0], 11);
    check("s1_w1", wr_log[0][1], 12);
    check("s1_w2", wr_log[0][2], 15);
    check("s1_en_cycles", en_cyc[0], 3);

    // Rejected range, then an empty request.
    clear_log();
    do_start(0, 126, 3);
    repeat (3) step();
    check("s2_err_cnt", err_cnt[0], 1);
    check("s2_no_write", wr_cnt[0], 0);
    check("s2_addr_kept", int'(addr_s[0]), 7);
    do_start(0, 20, 0);
    repeat (3) step();
    check("s2_zero_latency", done_cyc[0] - start_cyc[0], 1);
    check("s2_zero_done", done_cnt[0], 1);
    check("s2_zero_no_en", en_cyc[0], 0);

    // Backpressure: 5 idle FETCH cycles before the second bit.
    clear_log();
    do_start(0, 10, 2);
    send_bit(0, 1'b0, 0);
    send_bit(0, 1'b1, 5);
    repeat (8) step();
    check("s3_latency", done_cyc[0] - start_cyc[0], 14);
    check("s3_w0", wr_log[0][0], 20);
    check("s3_w1", wr_log[0][1], 23);

    // Stretched timing 2/3/2.
    clear_log();
    do_start(1, 20, 2);
    send_bit(1, 1'b1, 0);
    send_bit(1, 1'b1, 0);
    repeat (10) step();
    check("s4_latency", done_cyc[1] - start_cyc[1], 17);
    check("s4_en_cycles", en_cyc[1], 6);
    check("s4_w0", wr_log[1][0], 41);
    check("s4_w1", wr_log[1][1], 43);

    // Abort in the 2nd PULSE cycle, then start+abort together in IDLE.
    clear_log();
    do_start(1, 40, 3);
    send_bit(1, 1'b1, 0);
    wait_enable(1);
    step();
    abort_s[1] = 1'b1;
    step();
    abort_s[1] = 1'b0;
    check("s5_enable_low", int'(enable_s[1]), 0);
    check("s5_busy_low", int'(busy_s[1]), 0);
    repeat (5) step();
    check("s5_no_done", done_cnt[1], 0);
    check("s5_en_cycles", en_cyc[1], 2);
    abort_s[1] = 1'b1;
    start_s[1] = 1'b1;
    base_s[1] = 7'd0;
    nb_s[1] = 8'd1;
    step();
    abort_s[1] = 1'b0;
    start_s[1] = 1'b0;
    repeat (3) step();
    check("s5_dropped_busy", int'(busy_s[1]), 0);
    check("s5_dropped_done", done_cnt[1], 0);
    check("s5_dropped_err", err_cnt[1], 0);

    // Reset during HOLD of bit 2, then a one-bit run from address 0.
    clear_log();
    do_start(0, 50, 3);
    send_bit(0, 1'b1, 0);
    send_bit(0, 1'b0, 0);
    step();
    step();
    rst_s[0] = 1'b1;
    step();
    check("s6_rst_address", int'(addr_s[0]), 0);
    check("s6_rst_busy", int'(busy_s[0]), 0);
    check("s6_rst_enable", int'(enable_s[0]), 0);
    check("s6_rst_data", int'(data_s[0]), 0);
    rst_s[0] = 1'b0;
    step();
    clear_log();
    do_start(0, 0, 1);
    send_bit(0, 1'b1, 0);
    repeat (6) step();
    check("s6_latency", done_cyc[0] - start_cyc[0], 5);
    check("s6_w0", wr_log[0][0], 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_bank_cfg_loader.md
Name: mem_bank_cfg_loader

Overview:
Configuration-bitstream sequencer that sits directly upstream of the connection/switch block memory banks. It consumes a serial bitstream over a valid/ready handshake and produces the `enable`/`address`/`data_in` write cycles those banks expect, one bit per address. Programming covers a contiguous address window starting at `base_addr`, with configurable setup/pulse/hold timing around each `enable` strobe.

Parameters:
- ADDR_WIDTH, 7, width of the bank address bus (top bits select the decoder, low bits the mem word).
- SETUP_CYCLES, 1, cycles `address`/`data_in` are stable before `enable` rises; must be ≥1.
- PULSE_CYCLES, 1, cycles `enable` is held high; must be ≥1.
- HOLD_CYCLES, 1, cycles `address`/`data_in` are held after `enable` falls; must be ≥1.

Ports:
- prog_clk  in  1  programming clock; all logic on the rising edge.
- pReset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; `base_addr`/`num_bits` are sampled with it.
- base_addr  in  ADDR_WIDTH  first bank address to program.
- num_bits  in  ADDR_WIDTH+1  number of bits to write (0..2^ADDR_WIDTH).
- abort  in  1  cancels the current operation.
- bs_valid  in  1  bitstream bit valid.
- bs_data  in  1  bitstream bit.
- bs_ready  out  1  loader accepts a bit this cycle.
- enable  out  1  bank write strobe.
- address  out  [0:ADDR_WIDTH-1]  bank address; `address[0]` is the MSB.
- data_in  out  1  bit being written.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse on normal completion.
- error  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- One clock, `prog_clk`; `pReset` is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, counters 0.
- States: IDLE, FETCH, SETUP, PULSE, HOLD, DONE.
- IDLE → FETCH when `start`=1, `num_bits`≠0 and `base_addr`+`num_bits` ≤ 2^ADDR_WIDTH.
  - On this transition, `address` is loaded with `base_addr` and the remaining count with `num_bits`.
- `start` with `num_bits`=0 → DONE: `done` pulses the next cycle; `enable` never rises.
- `start` with a range overflow → stay IDLE and pulse `error` for one cycle; no `enable`, `address` unchanged.
- `start` while `busy`=1 is ignored (no error).
- FETCH:
  - `bs_ready`=1; `bs_ready` is combinational from state, 1 only in FETCH and not gated by `bs_valid`.
  - Transfer occurs when `bs_valid && bs_ready`: `data_in` ← `bs_data`, then → SETUP.
  - If `bs_valid`=0, stay in FETCH with `enable`=0 and `address`/`data_in` held.
- SETUP: stays SETUP_CYCLES cycles, `enable`=0, then → PULSE.
- PULSE: `enable`=1 for exactly PULSE_CYCLES cycles, then → HOLD. `enable` is registered, so it is high exactly while in PULSE.
- HOLD: `enable`=0 for HOLD_CYCLES cycles, then:
  - remaining count decrements;
  - if it reaches 0 → DONE;
  - otherwise `address` increments by 1 and → FETCH.
- Wrap-around: `address` never wraps, because range checking at start guarantees the last address is ≤ 2^ADDR_WIDTH−1. After the final bit, `address` holds the last programmed address.
- DONE: `done`=1 for one cycle, `busy`=0 in the same cycle, → IDLE.
- `busy`=1 in FETCH/SETUP/PULSE/HOLD.
- Minimum cost per bit = 1+SETUP+PULSE+HOLD cycles (4 at defaults).
- `abort`=1 in any busy state: next edge → IDLE with `enable`=0, `busy`=0, no `done`, `address`/`data_in` held. A half-pulse is acceptable; the bank re-programs on the next run.
- `abort` and `start` in the same IDLE cycle: `abort` wins, request dropped.
- `pReset` mid-operation: next edge forces all reset values, overriding `abort`/`start`.

Decomposition:
- Shared package `mem_bank_cfg_pkg`:
  - state enum `cfg_state_t`;
  - function computing the timer width from max(SETUP, PULSE, HOLD).
- One natural sub-module, `mem_bank_pulse_timer`: loadable down-counter with a zero flag, reused for the SETUP/PULSE/HOLD phases.
- The FSM, address counter and remaining counter stay in the top module.

Test Plan:
- Normal run, defaults: start with `base_addr`=5, `num_bits`=3, bits 1,0,1 streamed back-to-back → `address` 5,6,7, each with one 1-cycle `enable` while `data_in`=1,0,1; SETUP/HOLD gaps of 1 cycle; `done` pulses 1 cycle after the last HOLD; 13 cycles start→done.
- Rejected request: `base_addr`=126, `num_bits`=3 → `error`=1 for one cycle, `busy`/`enable` stay 0. Then `num_bits`=0 → `done` next cycle with no `enable`.
- Backpressure: `bs_valid` low for 5 cycles between bits → `bs_ready` stays 1, `enable` stays 0, `address` stable; programming resumes with the correct `data_in`.
- Timing parameters SETUP=2, PULSE=3, HOLD=2: each write shows `address` stable 2 cycles before `enable`, `enable` high exactly 3 cycles, then 2 hold cycles.
- `abort` asserted in the 2nd PULSE cycle of bit 1 (PULSE=3) → `enable` low next cycle, `busy`=0, no `done`. `start` in the same cycle as `abort` in IDLE → ignored.
- `pReset` asserted during HOLD of bit 2 → all outputs 0 at the next edge. A subsequent normal start with `base_addr`=0, `num_bits`=1 completes correctly.
